// File: rtl/tdc_decode_scheduler.sv
// Shares one pipelined thermometer-to-binary decoder among NCH TDC channels:
// per-channel capture slots, round-robin grant, tag pipe aligned to decoder latency.
module tdc_decode_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 40,
    parameter int unsigned DEC_LAT = 7,
    parameter int unsigned CW      = 16,
    parameter int unsigned PW      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         hit_valid,
    input  logic [NCH*DW-1:0]      hit_code,
    output logic [DW-1:0]          dec_code,
    input  logic [PW-1:0]          dec_pos,
    output logic                   res_valid,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic [PW-1:0]          res_fine,
    output logic [CW-1:0]          res_coarse,
    output logic [NCH-1:0]         ovf_flags,
    input  logic                   ovf_clr
);

    localparam int unsigned CHW = $clog2(NCH);
    // Stage 0 loads alongside dec_code; the tail lines up with the cycle dec_pos is valid.
    localparam int unsigned TAG_DEPTH = DEC_LAT + 1;

    typedef struct packed {
        logic           vld;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  crs;
    } tag_t;

    logic [CW-1:0]  coarse;
    logic [NCH-1:0] slot_pend;
    logic [DW-1:0]  slot_code [NCH];
    logic [CW-1:0]  slot_crs  [NCH];
    logic [CHW-1:0] rr;

    logic           gnt_any;
    logic [CHW-1:0] gnt_idx;
    logic [NCH-1:0] gnt_vec;
    logic [NCH-1:0] drop;
    tag_t           tag_in;
    tag_t           tag_pipe [TAG_DEPTH];
    tag_t           tag_tail;

    function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] base,
                                                input int unsigned   off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH) s = s - NCH;
        return CHW'(s);
    endfunction

    // Free-running coarse timestamp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coarse <= '0;
        else        coarse <= coarse + CW'(1);
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            if (!gnt_any && slot_pend[wrap_idx(rr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(rr, k);
            end
        end
        gnt_vec = '0;
        if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end

    assign drop = hit_valid & slot_pend & ~gnt_vec;

    always_comb begin
        tag_in     = '0;
        tag_in.vld = gnt_any;
        tag_in.ch  = gnt_idx;
        tag_in.crs = slot_crs[gnt_idx];
    end

    // Capture slots: a granted slot may be refilled in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_pend <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_code[i] <= '0;
                slot_crs[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (hit_valid[i] && (!slot_pend[i] || gnt_vec[i])) begin
                    slot_pend[i] <= 1'b1;
                    slot_code[i] <= hit_code[i*DW +: DW];
                    slot_crs[i]  <= coarse;
                end else if (gnt_vec[i]) begin
                    slot_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Decoder feed and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_code <= '0;
            rr       <= CHW'(NCH - 1);
        end else begin
            dec_code <= gnt_any ? slot_code[gnt_idx] : '0;
            if (gnt_any) rr <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < TAG_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_tail = tag_pipe[TAG_DEPTH-1];

    // Result register: data fields hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_fine   <= '0;
            res_coarse <= '0;
        end else begin
            res_valid <= tag_tail.vld;
            if (tag_tail.vld) begin
                res_ch     <= tag_tail.ch;
                res_fine   <= dec_pos;
                res_coarse <= tag_tail.crs;
            end
        end
    end

    // Sticky drop flags; a drop in the clearing cycle survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_flags <= '0;
        else        ovf_flags <= (ovf_clr ? '0 : ovf_flags) | drop;
    end

endmodule

// File: tb/tb_tdc_decode_scheduler.sv
// Bench for tdc_decode_scheduler: behavioural popcount decoder with DEC_LAT
// latency, scoreboard of expected results, one task per scenario.
module tb_tdc_decode_scheduler;

    localparam int unsigned NCH     = 4;
    localparam int unsigned DW      = 40;
    localparam int unsigned DEC_LAT = 7;
    localparam int unsigned CW      = 16;
    localparam int unsigned PW      = 6;
    localparam int unsigned CHW     = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     hit_valid;
    logic [NCH*DW-1:0]  hit_code;
    logic [DW-1:0]      dec_code;
    logic [PW-1:0]      dec_pos;
    logic               res_valid;
    logic [CHW-1:0]     res_ch;
    logic [PW-1:0]      res_fine;
    logic [CW-1:0]      res_coarse;
    logic [NCH-1:0]     ovf_flags;
    logic               ovf_clr;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [PW-1:0]  fine;
        logic [CW-1:0]  crs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [CW-1:0] tb_coarse;
    logic [PW-1:0] dpipe [DEC_LAT];

    tdc_decode_scheduler #(
        .NCH(NCH), .DW(DW), .DEC_LAT(DEC_LAT), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_code(hit_code),
        .dec_code(dec_code), .dec_pos(dec_pos), .res_valid(res_valid),
        .res_ch(res_ch), .res_fine(res_fine), .res_coarse(res_coarse),
        .ovf_flags(ovf_flags), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference coarse counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_coarse <= '0;
        else        tb_coarse <= tb_coarse + 16'd1;
    end

    // Decoder model: dec_pos updates DEC_LAT edges after the dec_code it belongs to
    always @(posedge clk) begin
        dpipe[0] <= PW'($countones(dec_code));
        for (int j = 1; j < DEC_LAT; j++) dpipe[j] <= dpipe[j-1];
    end
    assign dec_pos = dpipe[DEC_LAT-1];

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && res_valid) begin : mon
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got ch=%0d fine=%0d coarse=%0d, expected no result",
                         res_ch, res_fine, res_coarse);
            end else begin
                e = sb.pop_front();
                if ({res_ch, res_fine, res_coarse} !== e) begin
                    bad++;
                    $display("FAIL result: got ch=%0d fine=%0d coarse=%0d, expected ch=%0d fine=%0d coarse=%0d",
                             res_ch, res_fine, res_coarse, e.ch, e.fine, e.crs);
                end
            end
        end
    end

    function automatic logic [DW-1:0] therm(input int n);
        logic [63:0] v;
        v = (64'd1 << n) - 64'd1;
        return DW'(v);
    endfunction

    task automatic set_hit(input int ch, input int n);
        hit_valid[ch] = 1'b1;
        hit_code[ch*DW +: DW] = therm(n);
    endtask

    task automatic clear_hits;
        hit_valid = '0;
        hit_code  = '0;
    endtask

    task automatic push_exp(input int ch, input int n, input int c);
        exp_t e;
        e.ch   = CHW'(ch);
        e.fine = PW'(n);
        e.crs  = CW'(c);
        sb.push_back(e);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        clear_hits();
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic check_ovf(input string name, input logic [NCH-1:0] exp);
        total++;
        if (ovf_flags !== exp) begin
            bad++;
            $display("FAIL %s: ovf_flags=%b expected %b", name, ovf_flags, exp);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        total++;
        if (dec_code !== '0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: dec_code=%h res_valid=%b expected 0/0", dec_code, res_valid);
        end
        total++;
        if ({res_ch, res_fine, res_coarse} !== 24'd0) begin
            bad++;
            $display("FAIL reset_data: ch=%0d fine=%0d coarse=%0d expected all 0", res_ch, res_fine, res_coarse);
        end
        check_ovf("reset_ovf", 4'b0000);
    endtask

    task automatic test_single;
        int g, r;
        apply_reset();
        repeat (100) @(negedge clk);
        set_hit(2, 8);
        push_exp(2, 8, 100);
        @(negedge clk);
        clear_hits();
        g = -1;
        for (int i = 0; i < 10 && g < 0; i++) begin
            if (dec_code != '0) g = cyc;
            else @(negedge clk);
        end
        total++;
        if (dec_code !== therm(8)) begin
            bad++;
            $display("FAIL single_dec_code: dec_code=%h expected %h", dec_code, therm(8));
        end
        r = -1;
        for (int i = 0; i < 30 && r < 0; i++) begin
            if (res_valid) r = cyc;
            else @(negedge clk);
        end
        total++;
        if (g < 0 || r < 0 || (r - g) != int'(DEC_LAT + 1)) begin
            bad++;
            $display("FAIL single_latency: grant->result edges=%0d expected %0d", r - g, DEC_LAT + 1);
        end
        drain("single");
        check_ovf("single_ovf", 4'b0000);
    endtask

    task automatic test_all_channels;
        int n [4];
        apply_reset();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n[i] = 3 + i * 5;
            set_hit(i, n[i]);
            push_exp(i, n[i], 5);
        end
        @(negedge clk);
        clear_hits();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (dec_code !== therm(n[i])) begin
                bad++;
                $display("FAIL all_dec_code%0d: dec_code=%h expected %h", i, dec_code, therm(n[i]));
            end
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (res_valid !== 1'b1 || res_ch !== CHW'(i)) begin
                bad++;
                $display("FAIL all_burst%0d: res_valid=%b ch=%0d expected 1/%0d", i, res_valid, res_ch, i);
            end
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL all_burst_end: res_valid=%b expected 0", res_valid);
        end
        drain("all");
    endtask

    task automatic test_overflow;
        int c;
        apply_reset();
        c = int'(tb_coarse);
        set_hit(0, 4);
        set_hit(1, 6);
        push_exp(0, 4, c);
        push_exp(1, 6, c);
        @(negedge clk);
        clear_hits();
        set_hit(1, 10);
        @(negedge clk);
        clear_hits();
        check_ovf("ovf_set", 4'b0010);
        drain("ovf");
        check_ovf("ovf_sticky", 4'b0010);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_ovf("ovf_clear", 4'b0000);
        // Drop coinciding with clear: set must win
        c = int'(tb_coarse);
        set_hit(1, 5);
        set_hit(2, 7);
        push_exp(2, 7, c);
        push_exp(1, 5, c);
        @(negedge clk);
        clear_hits();
        set_hit(1, 9);
        ovf_clr = 1'b1;
        @(negedge clk);
        clear_hits();
        ovf_clr = 1'b0;
        check_ovf("ovf_set_wins", 4'b0010);
        drain("ovf_set_wins");
    endtask

    task automatic test_refill;
        int c;
        apply_reset();
        @(negedge clk);
        c = int'(tb_coarse);
        set_hit(0, 12);
        push_exp(0, 12, c);
        @(negedge clk);
        set_hit(0, 20);
        push_exp(0, 20, c + 1);
        @(negedge clk);
        clear_hits();
        drain("refill");
        check_ovf("refill_ovf", 4'b0000);
    endtask

    task automatic test_fairness;
        int c;
        logic [DW-1:0] exp_code;
        apply_reset();
        @(negedge clk);
        c = int'(tb_coarse);
        push_exp(0, 2, c);
        push_exp(3, 30, c);
        push_exp(0, 2, c + 1);
        push_exp(3, 30, c + 2);
        push_exp(0, 2, c + 3);
        push_exp(3, 30, c + 4);
        push_exp(0, 2, c + 5);
        for (int k = 0; k < 8; k++) begin
            clear_hits();
            if (k < 6) begin
                set_hit(0, 2);
                set_hit(3, 30);
            end
            @(negedge clk);
            if (k == 0) exp_code = '0;
            else        exp_code = (k % 2 == 1) ? therm(2) : therm(30);
            total++;
            if (dec_code !== exp_code) begin
                bad++;
                $display("FAIL fair_grant%0d: dec_code=%h expected %h", k, dec_code, exp_code);
            end
        end
        clear_hits();
        check_ovf("fair_ovf", 4'b1001);
        drain("fair");
    endtask

    task automatic test_reset_midflight;
        bit seen;
        apply_reset();
        set_hit(0, 5);
        set_hit(1, 6);
        set_hit(2, 7);
        @(negedge clk);
        clear_hits();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (dec_code !== '0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_assert: dec_code=%h res_valid=%b expected 0/0", dec_code, res_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet: res_valid seen=%b expected 0", seen);
        end
        set_hit(3, 11);
        push_exp(3, 11, 20);
        @(negedge clk);
        clear_hits();
        drain("midrst");
    endtask

    initial begin
        rst_n     = 1'b0;
        hit_valid = '0;
        hit_code  = '0;
        ovf_clr   = 1'b0;
        test_reset();
        test_single();
        test_all_channels();
        test_overflow();
        test_refill();
        test_fairness();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
